// File: rtl/prince_sbox_layer_ctrl.sv
// PRINCE masked S-box layer controller: streams the 16 nibbles of every share through an
// external pipelined masked S-box and reassembles the result. Inverse select: PRINCE_SBOX_INV_EN.
module prince_sbox_layer_ctrl #(
  parameter int SHARES   = 3,
  parameter int SBOX_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [64*SHARES-1:0] state_i,
  output logic                 ready_o,
  output logic                 done_o,
  output logic [64*SHARES-1:0] state_o,
  output logic [4*SHARES-1:0]  sbox_in_o,
  output logic                 sbox_vld_o,
  input  logic [4*SHARES-1:0]  sbox_out_i
`ifdef PRINCE_SBOX_INV_EN
  ,
  input  logic                 inv_i,
  output logic                 sbox_inv_o
`endif
);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

  state_t                          r_fsm, w_fsm_nxt;
  logic [64*SHARES-1:0]            r_state;
  logic [64*SHARES-1:0]            r_res;
  logic [64*SHARES-1:0]            r_state_o;
  logic [3:0]                      r_idx;
  logic                            r_vld;
  logic [4*SHARES-1:0]             r_sbox_in;
  logic [SBOX_LAT-1:0]             r_dl_vld;
  logic [SBOX_LAT-1:0][3:0]        r_dl_idx;
  logic                            r_inv;

  logic                            w_accept;
  logic                            w_cap;
  logic [3:0]                      w_cap_idx;
  logic                            w_last_cap;
  logic [64*SHARES-1:0]            w_res_nxt;

  // Per-share nibble select; each share is sliced independently so shares never mix.
  function automatic logic [4*SHARES-1:0] get_nib(input logic [64*SHARES-1:0] st,
                                                  input logic [3:0]           idx);
    logic [4*SHARES-1:0] r;
    r = '0;
    for (int s = 0; s < SHARES; s++) begin
      r[4*s +: 4] = st[64*s + 4*idx +: 4];
    end
    return r;
  endfunction

  function automatic logic [64*SHARES-1:0] put_nib(input logic [64*SHARES-1:0] st,
                                                   input logic [3:0]           idx,
                                                   input logic [4*SHARES-1:0]  nib);
    logic [64*SHARES-1:0] r;
    r = st;
    for (int s = 0; s < SHARES; s++) begin
      r[64*s + 4*idx +: 4] = nib[4*s +: 4];
    end
    return r;
  endfunction

  assign w_accept   = (r_fsm == IDLE) && start_i;
  assign w_cap      = r_dl_vld[SBOX_LAT-1];
  assign w_cap_idx  = r_dl_idx[SBOX_LAT-1];
  assign w_last_cap = w_cap && (w_cap_idx == 4'hF);
  assign w_res_nxt  = put_nib(r_res, w_cap_idx, sbox_out_i);

  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      IDLE:    if (start_i) w_fsm_nxt = FEED;
      FEED:    if (r_idx == 4'hF) w_fsm_nxt = DRAIN;
      DRAIN:   if (w_last_cap) w_fsm_nxt = DONE;
      DONE:    w_fsm_nxt = IDLE;
      default: w_fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm     <= IDLE;
      r_idx     <= 4'h0;
      r_vld     <= 1'b0;
      r_sbox_in <= '0;
      r_dl_vld  <= '0;
      r_dl_idx  <= '0;
      r_state_o <= '0;
      r_inv     <= 1'b0;
    end else begin
      r_fsm <= w_fsm_nxt;
      // Issue stage: sbox_in_o always comes straight from r_sbox_in.
      if (w_accept) begin
        r_idx     <= 4'h0;
        r_vld     <= 1'b1;
        r_sbox_in <= get_nib(state_i, 4'h0);
`ifdef PRINCE_SBOX_INV_EN
        r_inv     <= inv_i;
`endif
      end else if (r_fsm == FEED) begin
        if (r_idx == 4'hF) begin
          r_vld     <= 1'b0;
          r_sbox_in <= '0;
        end else begin
          r_idx     <= r_idx + 4'd1;
          r_sbox_in <= get_nib(r_state, r_idx + 4'd1);
        end
      end
      // Capture steering follows the S-box pipeline, independent of the FSM.
      r_dl_vld[0] <= r_vld;
      r_dl_idx[0] <= r_idx;
      for (int j = SBOX_LAT - 1; j > 0; j--) begin
        r_dl_vld[j] <= r_dl_vld[j-1];
        r_dl_idx[j] <= r_dl_idx[j-1];
      end
      if (w_last_cap && (r_fsm == DRAIN)) r_state_o <= w_res_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_state <= state_i;
    if (w_cap)    r_res   <= w_res_nxt;
  end

  assign ready_o    = (r_fsm == IDLE);
  assign done_o     = (r_fsm == DONE);
  assign state_o    = r_state_o;
  assign sbox_in_o  = r_sbox_in;
  assign sbox_vld_o = r_vld;
`ifdef PRINCE_SBOX_INV_EN
  assign sbox_inv_o = r_inv;
`endif

endmodule

// File: tb/tb_prince_sbox_layer_ctrl.sv
// Scoreboard bench for prince_sbox_layer_ctrl with a re-sharing PRINCE S-box model
// (SHARES=2, SBOX_LAT=2). Exercises the inverse path when PRINCE_SBOX_INV_EN is defined.
module tb_prince_sbox_layer_ctrl;
  localparam int SHARES   = 2;
  localparam int SBOX_LAT = 2;
  localparam int LATENCY  = 17 + SBOX_LAT;
  localparam logic [63:0] FWD_TBL = 64'h4D5E087619CA23FB;
  localparam logic [63:0] INV_TBL = 64'h1CE5046A98DF237B;
  localparam logic [63:0] PT      = 64'h0123456789ABCDEF;
  localparam logic [63:0] CT      = 64'hBF32AC916780E5D4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start_i = 1'b0;
  logic [64*SHARES-1:0] state_i = '0;
  logic                 ready_o, done_o, sbox_vld_o;
  logic [64*SHARES-1:0] state_o;
  logic [4*SHARES-1:0]  sbox_in_o, sbox_out_i;
  logic                 w_inv;
  logic [7:0]           pipe [SBOX_LAT];

`ifdef PRINCE_SBOX_INV_EN
  logic inv_i = 1'b0;
  logic sbox_inv_o;
  assign w_inv = sbox_inv_o;
`else
  assign w_inv = 1'b0;
`endif

  prince_sbox_layer_ctrl #(.SHARES(SHARES), .SBOX_LAT(SBOX_LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .state_i    (state_i),
    .ready_o    (ready_o),
    .done_o     (done_o),
    .state_o    (state_o),
    .sbox_in_o  (sbox_in_o),
    .sbox_vld_o (sbox_vld_o),
    .sbox_out_i (sbox_out_i)
`ifdef PRINCE_SBOX_INV_EN
    ,
    .inv_i      (inv_i),
    .sbox_inv_o (sbox_inv_o)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] sb(input logic [3:0] x, input logic inv);
    logic [63:0] t;
    t = inv ? INV_TBL : FWD_TBL;
    return t[4*x +: 4];
  endfunction

  // Unmask, substitute, re-share with a fresh random mask in share 1.
  function automatic logic [7:0] reshare(input logic [7:0] in, input logic inv, input logic [31:0] r);
    return {r[3:0], sb(in[3:0] ^ in[7:4], inv) ^ r[3:0]};
  endfunction

  always @(posedge clk) begin
    pipe[0] <= reshare(sbox_in_o, w_inv, $urandom);
    for (int j = SBOX_LAT - 1; j > 0; j--) pipe[j] <= pipe[j-1];
  end
  assign sbox_out_i = pipe[SBOX_LAT-1];

  typedef struct packed {
    logic [63:0] exp;
    int          acc;
  } item_t;

  item_t       q[$];
  int          total = 0;
  int          bad = 0;
  logic [63:0] pend_exp = '0;
  logic [63:0] pend_in = '0;
  logic [63:0] cur_in = '0;
  logic [127:0] prev_so = '0;
  int          vrun = 0;
  int          last_done = -1;
  bit          chk_reacc = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pushes on acceptance, pops and compares on done_o.
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        vrun    = 0;
        prev_so = state_o;
      end else begin
        if (done_o) begin
          chk("ready_in_done", 128'(ready_o), 128'(0));
          if (q.size() == 0) begin
            chk("spurious_done", 128'(done_o), 128'(0));
          end else begin
            it = q.pop_front();
            chk("latency", 128'(cyc - it.acc), 128'(LATENCY));
            chk("result", 128'(state_o[63:0] ^ state_o[127:64]), 128'(it.exp));
          end
          last_done = cyc;
        end else begin
          chk("state_o_hold", state_o, prev_so);
        end
        prev_so = state_o;
        if (ready_o && start_i) begin
          if (chk_reacc && last_done >= 0) chk("reaccept_cycle", 128'(cyc), 128'(last_done + 1));
          it.exp = pend_exp;
          it.acc = cyc;
          q.push_back(it);
          cur_in = pend_in;
        end
        if (sbox_vld_o) begin
          chk("issue_nibble", 128'(sbox_in_o[3:0] ^ sbox_in_o[7:4]), 128'(cur_in[4*vrun +: 4]));
          vrun++;
        end else if (vrun != 0) begin
          chk("vld_run_len", 128'(vrun), 128'(16));
          vrun = 0;
        end
      end
    end
  end

  task automatic wait_done();
    bit got;
    got = 1'b0;
    for (int i = 0; i < LATENCY + 20; i++) begin
      @(negedge clk);
      if (done_o) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("done_timeout", 128'(got), 128'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic start_vec(input logic [63:0] s0, input logic [63:0] s1, input logic [63:0] exp);
    pend_exp = exp;
    pend_in  = s0 ^ s1;
    state_i  = {s1, s0};
    start_i  = 1'b1;
    @(posedge clk);
    #1;
    start_i  = 1'b0;
    state_i  = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"},   128'(ready_o),    128'(1));
    chk({tag, "_done"},    128'(done_o),     128'(0));
    chk({tag, "_vld"},     128'(sbox_vld_o), 128'(0));
    chk({tag, "_sbox_in"}, 128'(sbox_in_o),  128'(0));
    chk({tag, "_state_o"}, state_o,          128'(0));
  endtask

  initial begin
    logic [63:0] m;
    int          n;
    #1;
    check_reset_outputs("por");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    start_vec(PT, 64'h0, CT);
    wait_done();

    m = 64'hA5A5A5A5A5A5A5A5;
    start_vec(PT ^ m, m, CT);
    wait_done();

    m = {$urandom, $urandom};
    start_vec(m, m, 64'hBBBBBBBBBBBBBBBB);
    wait_done();
    m = {$urandom, $urandom};
    start_vec(~m, m, 64'h4444444444444444);
    wait_done();

    // start_i held across two back-to-back runs.
    pend_exp  = CT;
    pend_in   = PT;
    m         = 64'h3C3C3C3C3C3C3C3C;
    state_i   = {m, PT ^ m};
    chk_reacc = 1'b1;
    last_done = -1;
    start_i   = 1'b1;
    n = 0;
    for (int i = 0; i < 3 * LATENCY; i++) begin
      @(negedge clk);
      if (done_o) begin
        n++;
        if (n == 2) begin
          start_i = 1'b0;
          break;
        end
      end
    end
    chk("held_start_runs", 128'(n), 128'(2));
    chk_reacc = 1'b0;
    @(posedge clk);
    #1;

    // Reset during FEED cycle 7 aborts the run.
    start_vec(PT, 64'h0, CT);
    repeat (7) @(posedge clk);
    #2;
    chk("pre_abort_vld", 128'(sbox_vld_o), 128'(1));
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    q.delete();
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("idle_after_abort", 128'(ready_o), 128'(1));
    m = 64'h5A5A5A5A0F0F0F0F;
    start_vec(PT ^ m, m, CT);
    wait_done();

`ifdef PRINCE_SBOX_INV_EN
    inv_i = 1'b1;
    start_vec(CT, 64'h0, PT);
    inv_i = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    chk("inv_held", 128'(sbox_inv_o), 128'(1));
    wait_done();
`endif

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/prince_sbox_layer_ctrl.md
PRINCE_SBOX_LAYER_CTRL -- requirements
Module: prince_sbox_layer_ctrl

Interface
REQ-001 Parameter SHARES, default 3: number of Boolean shares per state bit, legal range 2..4.
REQ-002 Parameter SBOX_LAT, default 2: register stages of the external masked S-box instance, legal range 1..4.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start_i  input  1  request to process one S-box layer; accepted only when ready_o=1.
REQ-006 state_i  input  64*SHARES  masked state; share s at bits [64*s+63:64*s]; sampled at acceptance.
REQ-007 ready_o  output  1  controller idle, start_i will be accepted.
REQ-008 done_o  output  1  one-cycle pulse, state_o holds a complete result.
REQ-009 state_o  output  64*SHARES  masked S-box layer result, same share packing as state_i.
REQ-010 sbox_in_o  output  4*SHARES  nibble to masked S-box; share s at bits [4*s+3:4*s].
REQ-011 sbox_vld_o  output  1  sbox_in_o carries a valid nibble this cycle.
REQ-012 sbox_out_i  input  4*SHARES  masked S-box output, same share packing as sbox_in_o.

Function
REQ-013 FSM states SHALL be IDLE, FEED, DRAIN, DONE; IDLE is the reset state.
REQ-014 IDLE: ready_o=1; start_i=1 loads state_i into internal register, clears nibble counters, moves to FEED.
REQ-015 FEED: lasts exactly 16 cycles; in FEED cycle k (k=0..15) sbox_vld_o=1 and sbox_in_o = nibble k of every share (bits [4k+3:4k] of each share).
REQ-016 A nibble issued in cycle t SHALL be captured from sbox_out_i in cycle t+SBOX_LAT and written to nibble position k of every share of the result register; capture is steered by a SBOX_LAT-deep valid/index delay line, not by the FSM.
REQ-017 After the 16th issue the FSM SHALL enter DRAIN with sbox_vld_o=0 and sbox_in_o=0; DRAIN exits when the 16th result is captured.
REQ-018 DONE: lasts one cycle; done_o=1; then return to IDLE.
REQ-019 Start acceptance in cycle 0 SHALL give done_o=1 in cycle 17+SBOX_LAT; no other latency is permitted.
REQ-020 start_i while ready_o=0 SHALL be ignored with no effect on the running operation.
REQ-021 start_i in the DONE cycle is ignored; ready_o=0 in DONE; earliest new acceptance is the following IDLE cycle.
REQ-022 state_o SHALL be updated only in the DONE cycle and held stable until the next DONE; intermediate captures are not visible on state_o.
REQ-023 Shares SHALL never be combined: no logic may mix bits of different shares of state_i, state_o or sbox_out_i.
REQ-024 sbox_in_o SHALL be driven directly from a register (no combinational path from start_i or state_i), to preserve glitch-free share separation toward the masked S-box.

Reset
REQ-025 rst_n=0 SHALL force, asynchronously: FSM=IDLE, counters and delay line cleared, ready_o=1, done_o=0, sbox_vld_o=0, sbox_in_o=0, state_o=0.
REQ-026 Reset mid-operation SHALL abort the run; results arriving from the S-box after reset release SHALL be discarded.

Configuration
REQ-027 Macro PRINCE_SBOX_INV_EN defined: ports inv_i (input 1) and sbox_inv_o (output 1) exist; inv_i is latched at start acceptance and drives sbox_inv_o constant for the whole run (selects inverse S-box); sbox_inv_o resets to 0.
REQ-028 Macro PRINCE_SBOX_INV_EN undefined: inv_i and sbox_inv_o do not exist; forward S-box only; all other behaviour identical.

Verification (SHARES=2, SBOX_LAT=2, bench S-box model = PRINCE S-box B F 3 2 A C 9 1 6 7 8 0 E 5 D 4 applied to unmasked value, re-shared)
REQ-029 Reset, then start with share0=0x0123456789ABCDEF, share1=0 -> done_o in cycle 19 after acceptance; share0^share1 of state_o = 0xBF32AC916780E5D4.
REQ-030 Same value masked with share1=0xA5A5A5A5A5A5A5A5 random shares -> XOR of state_o shares = 0xBF32AC916780E5D4; sbox_vld_o high exactly 16 consecutive cycles, nibble 0 first.
REQ-031 start_i held high throughout two runs -> second acceptance occurs exactly one cycle after first done_o; start_i during FEED/DRAIN/DONE ignored.
REQ-032 rst_n pulsed low in FEED cycle 7 -> all outputs at reset values immediately; no done_o until a new start; a new run after reset gives correct result.
REQ-033 With PRINCE_SBOX_INV_EN, inv_i=1 at start, share0=0xBF32AC916780E5D4 -> sbox_inv_o=1 for the run, unmasked result 0x0123456789ABCDEF; inv_i toggled mid-run has no effect.
